// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - AES forward S-box applied to each byte of a 32-bit word
//
// Purpose: combinational SubWord. Each byte goes through the GF(2^8)
// multiplicative inverse (x^254, with 0 mapping to 0) and then the AES
// affine transform.
// Ports:
//   word_i  in  32  input word
//   word_o  out 32  S-box of each byte of word_i, byte positions preserved
module aes_sbox (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; repeated squaring accumulates the product.
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign word_o = {sbox_byte(word_i[31:24]), sbox_byte(word_i[23:16]),
                   sbox_byte(word_i[15:8]),  sbox_byte(word_i[7:0])};

endmodule

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - sequential AES-128/192/256 key schedule with round-key readback
//
// Purpose: expands a cipher key into the full AES word schedule, one word per
// clock, into a 60-word store. Any round key can then be read back by index.
// Ports:
//   clk_i         in   1            rising-edge clock
//   rst_i         in   1            asynchronous active-high reset
//   start_i       in   1            begin expansion (sampled only when idle)
//   key_len_i     in   2            0=AES-128, 1=AES-192, 2=AES-256, 3=illegal
//   key_in_i      in   32*NK_MAX    cipher key, word 0 in the MSBs
//   busy_o        out  1            expansion in progress
//   done_o        out  1            one-cycle pulse, expansion complete
//   err_o         out  1            one-cycle pulse, start rejected
//   keys_valid_o  out  1            store holds a complete schedule
//   num_rounds_o  out  4            Nr of the stored schedule
//   rd_en_i       in   1            round-key read request
//   rd_idx_i      in   4            round index
//   rd_valid_o    out  1            rd_data_o valid
//   rd_err_o      out  1            one-cycle pulse, read refused
//   rd_data_o     out  128          round key, lowest word index in the MSBs
module aes_key_expander #(
  parameter int NK_MAX = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [1:0]           key_len_i,
  input  logic [32*NK_MAX-1:0] key_in_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 keys_valid_o,
  output logic [3:0]           num_rounds_o,
  input  logic                 rd_en_i,
  input  logic [3:0]           rd_idx_i,
  output logic                 rd_valid_o,
  output logic                 rd_err_o,
  output logic [127:0]         rd_data_o
);

  localparam int NWORDS = 60;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [31:0]  w_q [NWORDS];
  logic [7:0]   rcon_q, rcon_d;
  logic [5:0]   idx_q, idx_d;
  logic [2:0]   ph_q, ph_d;          // idx mod Nk, kept incrementally
  logic [3:0]   nk_q, nk_d;
  logic [3:0]   nr_q, nr_d;          // Nr of the expansion in flight
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         kv_q, kv_d;
  logic [3:0]   num_rounds_q, num_rounds_d;
  logic         rv_q, rv_d;
  logic         re_q, re_d;
  logic [127:0] rd_data_q, rd_data_d;

  // Key length decode
  logic [3:0] req_nk;
  logic [3:0] req_nr;
  logic       req_ok;

  always_comb begin
    req_nk = 4'd4;
    req_nr = 4'd10;
    req_ok = 1'b1;
    case (key_len_i)
      2'd0:    ;
      2'd1:    begin req_nk = 4'd6; req_nr = 4'd12; end
      2'd2:    begin req_nk = 4'd8; req_nr = 4'd14; end
      default: req_ok = 1'b0;
    endcase
    if (int'(req_nk) > NK_MAX) req_ok = 1'b0;
  end

  // Expansion datapath: one new word from w[i-1] and w[i-Nk]
  logic [31:0] prev_w, back_w, sbox_in, sbox_out, t_w, new_w;
  logic [5:0]  last_idx;

  assign prev_w  = w_q[idx_q - 6'd1];
  assign back_w  = w_q[idx_q - {2'b00, nk_q}];
  assign sbox_in = (ph_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  aes_sbox u_sbox (
    .word_i (sbox_in),
    .word_o (sbox_out)
  );

  always_comb begin
    t_w = prev_w;
    if (ph_q == 3'd0)                        t_w = sbox_out ^ {rcon_q, 24'h000000};
    else if (nk_q == 4'd8 && ph_q == 3'd4)   t_w = sbox_out;
  end

  assign new_w    = back_w ^ t_w;
  // Last word index is 4*(Nr+1)-1 = 4*Nr+3
  assign last_idx = {nr_q, 2'b11};

  // Round-key reads; a start seen in IDLE takes precedence over a read
  logic [5:0] rd_base;
  logic       rd_ok;

  assign rd_base = {rd_idx_i, 2'b00};
  assign rd_ok   = rd_en_i && kv_q && !busy_q && (rd_idx_i <= num_rounds_q) &&
                   !(state_q == S_IDLE && start_i);

  always_comb begin
    state_d      = state_q;
    rcon_d       = rcon_q;
    idx_d        = idx_q;
    ph_d         = ph_q;
    nk_d         = nk_q;
    nr_d         = nr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    kv_d         = kv_q;
    num_rounds_d = num_rounds_q;
    rv_d         = rd_ok;
    re_d         = rd_en_i && !rd_ok;
    rd_data_d    = rd_data_q;
    if (rd_ok) begin
      rd_data_d = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    end
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (req_ok) begin
            state_d = S_LOAD;
            busy_d  = 1'b1;
            kv_d    = 1'b0;
            rcon_d  = 8'h01;
            nk_d    = req_nk;
            nr_d    = req_nr;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        idx_d   = {2'b00, nk_q};
        ph_d    = 3'd0;
        state_d = S_EXPAND;
      end
      S_EXPAND: begin
        idx_d = idx_q + 6'd1;
        ph_d  = (ph_q == nk_q[2:0] - 3'd1) ? 3'd0 : ph_q + 3'd1;
        if (ph_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (idx_q == last_idx) state_d = S_DONE;
      end
      S_DONE: begin
        done_d       = 1'b1;
        kv_d         = 1'b1;
        num_rounds_d = nr_q;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      rcon_q       <= 8'h00;
      idx_q        <= 6'd0;
      ph_q         <= 3'd0;
      nk_q         <= 4'd0;
      nr_q         <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      kv_q         <= 1'b0;
      num_rounds_q <= 4'd0;
      rv_q         <= 1'b0;
      re_q         <= 1'b0;
      rd_data_q    <= 128'h0;
      for (int j = 0; j < NWORDS; j++) w_q[j] <= 32'h0;
    end else begin
      state_q      <= state_d;
      rcon_q       <= rcon_d;
      idx_q        <= idx_d;
      ph_q         <= ph_d;
      nk_q         <= nk_d;
      nr_q         <= nr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      kv_q         <= kv_d;
      num_rounds_q <= num_rounds_d;
      rv_q         <= rv_d;
      re_q         <= re_d;
      rd_data_q    <= rd_data_d;
      if (state_q == S_LOAD) begin
        for (int j = 0; j < NK_MAX; j++) begin
          if (j < int'(nk_q)) w_q[j] <= key_in_i[32*(NK_MAX-1-j) +: 32];
        end
      end else if (state_q == S_EXPAND) begin
        w_q[idx_q] <= new_w;
      end
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign keys_valid_o = kv_q;
  assign num_rounds_o = num_rounds_q;
  assign rd_valid_o   = rv_q;
  assign rd_err_o     = re_q;
  assign rd_data_o    = rd_data_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - self-checking bench for aes_key_expander
module tb_aes_key_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, rd_en;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [3:0]   rd_idx;
  logic         busy, done, err, keys_valid, rd_valid, rd_err;
  logic [3:0]   num_rounds;
  logic [127:0] rd_data;

  logic         start2;
  logic [1:0]   key_len2;
  logic [127:0] key_in2;
  logic         busy2, done2, err2, kv2, rv2, re2;
  logic [3:0]   nr2;
  logic [127:0] rd2;

  aes_key_expander #(.NK_MAX(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .key_len_i(key_len), .key_in_i(key_in),
    .busy_o(busy), .done_o(done), .err_o(err), .keys_valid_o(keys_valid),
    .num_rounds_o(num_rounds), .rd_en_i(rd_en), .rd_idx_i(rd_idx),
    .rd_valid_o(rd_valid), .rd_err_o(rd_err), .rd_data_o(rd_data)
  );

  aes_key_expander #(.NK_MAX(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .key_len_i(key_len2), .key_in_i(key_in2),
    .busy_o(busy2), .done_o(done2), .err_o(err2), .keys_valid_o(kv2),
    .num_rounds_o(nr2), .rd_en_i(1'b0), .rd_idx_i(4'd0),
    .rd_valid_o(rv2), .rd_err_o(re2), .rd_data_o(rd2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  sb [256];
  logic [31:0] mw [60];
  logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // S-box table from the generator walk: p steps by multiplication by 3,
  // q by division by 3, so q = p^-1 at every step.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    int ntot;
    logic [31:0] t;
    ntot = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) mw[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < ntot; i++) begin
      t = mw[i-1];
      if (i % nk == 0)                t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = sub_word(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int k);
    return {mw[4*k], mw[4*k+1], mw[4*k+2], mw[4*k+3]};
  endfunction

  task automatic run_expand(input logic [255:0] key, input logic [1:0] len, input int exp_cycles,
                            input int exp_nr, input string tag);
    int cnt;
    key_in = key; key_len = len; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy after start"}, busy, 1);
    check({tag, " keys_valid cleared"}, keys_valid, 0);
    cnt = 0;
    while (!done && cnt < 200) begin tick(); cnt++; end
    check({tag, " done latency"}, cnt, exp_cycles);
    check({tag, " busy at done"}, busy, 0);
    check({tag, " keys_valid at done"}, keys_valid, 1);
    check({tag, " num_rounds"}, num_rounds, exp_nr);
    tick();
    check({tag, " done one cycle"}, done, 0);
  endtask

  task automatic read_key(input int k, input logic [127:0] exp, input string tag);
    rd_idx = 4'(k); rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check({tag, " rd_valid"}, rd_valid, 1);
    check({tag, " rd_data"}, rd_data, exp);
  endtask

  task automatic check_all(input int nr, input string tag);
    for (int k = 0; k <= nr; k++) read_key(k, model_rk(k), $sformatf("%s rk%0d", tag, k));
    tick();
    check({tag, " rd_valid drops"}, rd_valid, 0);
  endtask

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [255:0] kr;
    logic [127:0] held;
    int cnt;

    build_sbox();
    rst = 1'b1; start = 1'b0; key_len = 2'd0; key_in = '0; rd_en = 1'b0; rd_idx = 4'd0;
    start2 = 1'b0; key_len2 = 2'd0; key_in2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset keys_valid", keys_valid, 0);
    check("reset num_rounds", num_rounds, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_err", rd_err, 0);
    check("reset rd_data", rd_data, 0);

    // Known-answer vectors
    run_expand(K128, 2'd0, 42, 10, "aes128");
    read_key(1, 128'ha0fafe1788542cb123a339392a6c7605, "aes128 kat idx1");
    read_key(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "aes128 kat idx10");
    model_expand(K128, 4);
    check_all(10, "aes128");
    rd_idx = 4'd11; rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("aes128 idx11 rd_err", rd_err, 1);
    check("aes128 idx11 rd_valid", rd_valid, 0);

    run_expand(K192, 2'd1, 48, 12, "aes192");
    read_key(12, 128'he98ba06f448c773c8ecc720401002202, "aes192 kat idx12");
    model_expand(K192, 6);
    check_all(12, "aes192");

    run_expand(K256, 2'd2, 54, 14, "aes256");
    model_expand(K256, 8);
    check_all(14, "aes256");
    read_key(14, 128'hfe4890d1e6188d0b046df344706c631e, "aes256 kat idx14");
    held = rd_data;
    rd_idx = 4'd15; rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("aes256 idx15 rd_err", rd_err, 1);
    check("aes256 idx15 rd_valid", rd_valid, 0);
    check("aes256 idx15 rd_data held", rd_data, 128'hfe4890d1e6188d0b046df344706c631e);
    tick();
    check("aes256 rd_err one cycle", rd_err, 0);
    check("aes256 rd_data still held", rd_data, held);

    // Illegal key length
    key_len = 2'd3; start = 1'b1;
    check("illegal err before edge", err, 0);
    tick();
    start = 1'b0;
    check("illegal err pulse", err, 1);
    check("illegal busy", busy, 0);
    check("illegal keys_valid kept", keys_valid, 1);
    check("illegal num_rounds kept", num_rounds, 14);
    tick();
    check("illegal err one cycle", err, 0);
    read_key(14, 128'hfe4890d1e6188d0b046df344706c631e, "after illegal idx14");

    // AES-256 on a 128-bit-only instance
    key_len2 = 2'd2; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("nk_max4 err pulse", err2, 1);
    check("nk_max4 busy", busy2, 0);
    check("nk_max4 keys_valid", kv2, 0);
    tick();
    check("nk_max4 err one cycle", err2, 0);

    // Start and read together in IDLE, then read and restart while busy
    kr = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    key_in = kr; key_len = 2'd0; start = 1'b1; rd_en = 1'b1; rd_idx = 4'd0;
    tick();
    start = 1'b0; rd_en = 1'b0;
    check("start wins rd_err", rd_err, 1);
    check("start wins rd_valid", rd_valid, 0);
    check("start wins busy", busy, 1);
    cnt = 0;
    repeat (10) begin tick(); cnt++; end
    rd_en = 1'b1; rd_idx = 4'd0; start = 1'b1; key_len = 2'd1; key_in = ~kr;
    tick(); cnt++;
    rd_en = 1'b0; start = 1'b0;
    check("busy read rd_err", rd_err, 1);
    check("busy read rd_valid", rd_valid, 0);
    check("second start ignored err", err, 0);
    while (!done && cnt < 200) begin tick(); cnt++; end
    check("busy scenario done latency", cnt, 42);
    check("busy scenario num_rounds", num_rounds, 10);
    model_expand(kr, 4);
    check_all(10, "busy scenario");

    // Reset in the middle of expansion
    key_in = K128; key_len = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (21) tick();
    #2 rst = 1'b1;
    #1;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset err", err, 0);
    check("midreset keys_valid", keys_valid, 0);
    check("midreset num_rounds", num_rounds, 0);
    check("midreset rd_valid", rd_valid, 0);
    check("midreset rd_err", rd_err, 0);
    check("midreset rd_data", rd_data, 0);
    tick();
    rst = 1'b0;
    tick();
    run_expand(K128, 2'd0, 42, 10, "after reset");
    read_key(1, 128'ha0fafe1788542cb123a339392a6c7605, "after reset kat idx1");
    read_key(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "after reset kat idx10");

    // Randomized keys in all modes
    for (int r = 0; r < 2; r++) begin
      for (int m = 0; m < 3; m++) begin
        kr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        run_expand(kr, 2'(m), 42 + 6*m, 10 + 2*m, $sformatf("rand%0d mode%0d", r, m));
        model_expand(kr, 4 + 2*m);
        check_all(10 + 2*m, $sformatf("rand%0d mode%0d", r, m));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Sequential, multi-mode AES key expansion engine supporting AES-128, AES-192 and AES-256. It computes one 32-bit schedule word per clock. All round keys are held in an internal word store, and any round key can be read back by index while the encrypt/decrypt datapath runs. It sits between the key-load interface and the round pipeline, replacing the combinational single-step scheduler. It shares the existing `aes_sbox` word S-box, with one instance for the whole block.

## Interface
- NK_MAX, 8, largest supported key length in 32-bit words (legal: 4, 6, 8); key_in width = 32*NK_MAX
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin expansion; sampled only in IDLE
- key_len  in  2  0=AES-128 (Nk=4, Nr=10), 1=AES-192 (Nk=6, Nr=12), 2=AES-256 (Nk=8, Nr=14), 3=illegal
- key_in  in  32*NK_MAX  cipher key, left-justified: word 0 = MSBs; unused low words ignored
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, expansion complete
- err  out  1  one-cycle pulse, start rejected (illegal key_len or Nk > NK_MAX)
- keys_valid  out  1  level, store holds a complete schedule
- num_rounds  out  4  Nr of stored schedule (10/12/14), 0 after reset
- rd_en  in  1  round-key read request
- rd_idx  in  4  round index 0..Nr
- rd_valid  out  1  rd_data valid, one cycle after accepted rd_en
- rd_err  out  1  one-cycle pulse, read refused
- rd_data  out  128  round key, word 4*rd_idx at [127:96]

## Operation
- Word store: 4*(14+1)=60 x 32-bit registers, indexed w[0..Ntot-1], Ntot = 4*(Nr+1) = 44/52/60.
- FSM states:
  - IDLE: accepts start. Legal key_len → LOAD; busy=1; keys_valid=0; rcon=0x01. Illegal → err pulse, no other state change.
  - LOAD (1 cycle): writes w[0..Nk-1] from key_in; i=Nk → EXPAND.
  - EXPAND (1 word/cycle): t = w[i-1].
    - i mod Nk == 0: t = SubWord(RotWord(t)) ^ {rcon,24'h0}, then rcon = xtime(rcon) (0x80 → 0x1b).
    - Nk==8 and i mod Nk == 4: t = SubWord(t), no Rcon.
    - w[i] = w[i-Nk] ^ t; i++.
    - After writing w[Ntot-1] → DONE.
  - DONE (1 cycle): done=1, keys_valid=1, num_rounds=Nr, busy=0 → IDLE.
- RotWord rotates left by one byte. SubWord uses the shared `aes_sbox`. All XORs are 32-bit, and the index counter is 6 bits.
- Reads: rd_en is accepted only when keys_valid=1, busy=0 and rd_idx ≤ num_rounds.
  - Accepted read: rd_data = {w[4k],w[4k+1],w[4k+2],w[4k+3]}, k=rd_idx, registered.
  - Refused read: rd_err pulses next cycle, rd_valid=0, rd_data holds its previous value.
- start outside IDLE is ignored (no err). start and rd_en in the same IDLE cycle: start wins and the read is refused.
- rst asserted at any time (including mid-EXPAND): FSM → IDLE, and all outputs, rcon, index and word store clear to 0.

## Timing
- Reset values: busy=0, done=0, err=0, keys_valid=0, num_rounds=0, rd_valid=0, rd_err=0, rd_data=0.
- Start accepted on edge E0. busy is high after E0.
- LOAD write occurs on E1. EXPAND writes occur on E2..E(1+Ntot-Nk).
- done and keys_valid rise after edge E(2+Ntot-Nk), i.e. 42/48/54 edges after E0 for 128/192/256. busy falls on the same edge.
- A new start is sampleable the cycle after done.
- err rises one edge after the illegal start is sampled.
- Read latency is 1 cycle: rd_en at edge R gives rd_valid/rd_data after edge R, held for exactly one cycle per request. Back-to-back reads are allowed every cycle.
- Combinational S-box path: w[i-1] → aes_sbox → XOR → store, within one cycle.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c → done 42 cycles after start; rd_idx=1 gives a0fafe1788542cb123a339392a6c7605; rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; num_rounds=10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done at 48 cycles; rd_idx=12 gives e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done at 54 cycles; rd_idx=14 gives fe4890d1e6188d0b046df344706c631e; rd_idx=15 → rd_err pulse, rd_valid=0.
- key_len=3 (and key_len=2 with NK_MAX=4) → err pulse after one edge, busy stays 0, prior keys_valid/num_rounds unchanged.
- Read during busy and second start mid-EXPAND → rd_err pulse; second start ignored; first expansion completes with correct keys.
- rst pulsed at EXPAND cycle 20 → all outputs 0 immediately. A fresh AES-128 start then reproduces the scenario-1 results exactly.
